// File: rtl/life_run_controller_pkg.sv
// life_run_controller_pkg
//   Shared definitions for the Game of Life run controller and its neighbours:
//   the one-hot mode encoding (also used by the setup and algorithm blocks) and
//   the tick-period helper used by the prescaler.
package life_run_controller_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SET   = 3'b001,
    MODE_RUN   = 3'b010,
    MODE_PAUSE = 3'b100
  } mode_e;

  // Tick period in clk cycles for a speed setting: base_div >> speed, never below 1.
  function automatic int unsigned tick_period(input int unsigned base_div,
                                              input logic [2:0]  speed);
    int unsigned p;
    p = base_div >> speed;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/life_run_controller_btn_conditioner.sv
// btn_conditioner
//   Conditions one asynchronous push-button: 2-FF synchroniser, debounce (a new
//   level is accepted once the synchronised input has differed from the accepted
//   level for DEBOUNCE_CYC consecutive cycles), then a 1-cycle rising-edge pulse.
// Ports:
//   clk      system clock
//   clr_i    synchronous clear of the whole conditioner (reset or controller clear)
//   btn_i    raw asynchronous button level
//   pulse_o  1-cycle pulse on each accepted press
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic clr_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Counter only runs while the synced input disagrees with the accepted
    // level; any return to agreement restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/life_run_controller.sv
// life_run_controller
//   Run/step scheduler for the Game of Life datapath. Conditions the clear/run/
//   step buttons, derives a speed-selectable generation tick from clk, owns the
//   SET/RUN/PAUSE mode, issues gen_start pulses, tracks the start/done handshake
//   and counts completed generations.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   btn_clear_i        abort and return to SET
//   btn_run_i          SET->RUN, RUN<->PAUSE
//   btn_step_i         single generation while in PAUSE and idle
//   speed_i            tick rate select (period = BASE_DIV >> speed_i, min 1)
//   gen_done_i         engine finished a generation (1-cycle pulse)
//   board_same_i       qualifies gen_done_i: board did not change
//   mode_o             one-hot mode (SET=001, RUN=010, PAUSE=100)
//   setup_en_o         high in SET
//   gen_start_o        1-cycle start pulse
//   busy_o             generation outstanding
//   generation_cnt_o   completed generations since SET entry (wraps)
//   overrun_o          sticky: a RUN tick arrived while busy
// Build option:
//   LIFE_AUTO_STOP_EN  when defined, an accepted done with board_same_i=1 in RUN
//                      moves the controller to PAUSE.
module life_run_controller
  import life_run_controller_pkg::*;
#(
  parameter int unsigned BASE_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_clear_i,
  input  logic             btn_run_i,
  input  logic             btn_step_i,
  input  logic [2:0]       speed_i,
  input  logic             gen_done_i,
  input  logic             board_same_i,
  output logic [2:0]       mode_o,
  output logic             setup_en_o,
  output logic             gen_start_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] generation_cnt_o,
  output logic             overrun_o
);

  localparam int unsigned PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  mode_e            mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       speed_q, speed_d;

  logic          clr_p, run_p, step_p;
  logic          cond_clr;
  logic [PW-1:0] period_last;
  logic          tick, step_ok, done_ok, gen_start;

  // Clear also wipes the button conditioners, including its own.
  assign cond_clr = reset | clr_p;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_clear (
    .clk(clk), .clr_i(cond_clr), .btn_i(btn_clear_i), .pulse_o(clr_p)
  );
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_run (
    .clk(clk), .clr_i(cond_clr), .btn_i(btn_run_i), .pulse_o(run_p)
  );
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_step (
    .clk(clk), .clr_i(cond_clr), .btn_i(btn_step_i), .pulse_o(step_p)
  );

`ifdef LIFE_AUTO_STOP_EN
`else
  logic unused_board_same;
  assign unused_board_same = board_same_i;
`endif

  always_comb begin
    mode_d    = mode_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    speed_d   = speed_i;

    // Period comes from the registered speed so gen_start_o depends on state only.
    period_last = PW'(tick_period(BASE_DIV, speed_q) - 32'd1);
    tick        = (mode_q == MODE_RUN) && (presc_q == period_last);
    // A run press in the same cycle outranks step.
    step_ok     = step_p && !run_p && (mode_q == MODE_PAUSE) && !busy_q;
    gen_start   = !clr_p && ((tick && !busy_q) || step_ok);
    done_ok     = !clr_p && gen_done_i && busy_q;

    if (clr_p) begin
      mode_d    = MODE_SET;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
      cnt_d     = '0;
      presc_d   = '0;
    end else begin
      if (run_p) begin
        case (mode_q)
          MODE_SET:   mode_d = MODE_RUN;
          MODE_RUN:   mode_d = MODE_PAUSE;
          MODE_PAUSE: mode_d = MODE_RUN;
          default:    mode_d = MODE_SET;
        endcase
      end
`ifdef LIFE_AUTO_STOP_EN
      else if (done_ok && board_same_i && (mode_q == MODE_RUN)) begin
        mode_d = MODE_PAUSE;
      end
`endif

      // Holding the count at zero outside RUN gives the full-period first tick.
      if ((mode_q != MODE_RUN) || (speed_i != speed_q) || tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end

      if (tick && busy_q) begin
        overrun_d = 1'b1;
      end

      if (gen_start) begin
        busy_d = 1'b1;
      end else if (done_ok) begin
        busy_d = 1'b0;
      end

      if (done_ok) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_SET;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
      presc_q   <= '0;
      speed_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      speed_q   <= speed_d;
    end
  end

  assign mode_o           = mode_q;
  assign setup_en_o       = (mode_q == MODE_SET);
  assign gen_start_o      = gen_start;
  assign busy_o           = busy_q;
  assign generation_cnt_o = cnt_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_life_run_controller.sv
// tb_life_run_controller
//   Randomised phases of button presses, speed changes and done responses,
//   compared every cycle with a behavioural model of the controller.
module tb_life_run_controller;

  localparam int unsigned BASE_DIV = 8;
  localparam int unsigned DEB      = 4;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_clear, btn_run, btn_step;
  logic [2:0]       speed;
  logic             gen_done, board_same;
  logic [2:0]       mode_o;
  logic             setup_en, gen_start, busy, overrun;
  logic [CNT_W-1:0] gen_cnt;

  always #5 clk = ~clk;

  life_run_controller #(
    .BASE_DIV(BASE_DIV),
    .DEBOUNCE_CYC(DEB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_clear_i(btn_clear),
    .btn_run_i(btn_run),
    .btn_step_i(btn_step),
    .speed_i(speed),
    .gen_done_i(gen_done),
    .board_same_i(board_same),
    .mode_o(mode_o),
    .setup_en_o(setup_en),
    .gen_start_o(gen_start),
    .busy_o(busy),
    .generation_cnt_o(gen_cnt),
    .overrun_o(overrun)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 = SET, 1 = RUN, 2 = PAUSE. Buttons: 0 = clear, 1 = run, 2 = step.
  int          m_mode;
  bit          m_busy, m_over;
  int unsigned m_cnt, m_presc;
  logic [2:0]  m_spd;
  bit          hist [3][DEB+1];  // [0] newest raw sample, [1..DEB] synced history
  bit          lvl  [3];
  bit          pls  [3];

  function automatic int unsigned period_of(input logic [2:0] s);
    int unsigned p;
    p = BASE_DIV >> s;
    return (p == 0) ? 1 : p;
  endfunction

  function automatic bit model_tick();
    return (m_mode == 1) && (m_presc == period_of(m_spd) - 1);
  endfunction

  function automatic bit model_start();
    bit step_ok;
    step_ok = pls[2] && !pls[1] && (m_mode == 2) && !m_busy;
    return !pls[0] && ((model_tick() && !m_busy) || step_ok);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_busy = 0; m_over = 0; m_cnt = 0; m_presc = 0; m_spd = '0;
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 0; pls[i] = 0;
      for (int j = 0; j <= DEB; j++) hist[i][j] = 0;
    end
  endtask

  task automatic model_step(input bit b0, input bit b1, input bit b2,
                            input bit done, input logic [2:0] spd_in);
    bit clr, run, tick, start, dok, all_diff, nl;
    bit raw [3];
    int old_mode;
    clr = pls[0]; run = pls[1];
    raw[0] = b0; raw[1] = b1; raw[2] = b2;
    old_mode = m_mode;
    tick  = model_tick();
    start = model_start();
    dok   = !clr && done && m_busy;
    if (clr) begin
      m_mode = 0; m_busy = 0; m_over = 0; m_cnt = 0; m_presc = 0;
    end else begin
      if (run) m_mode = (old_mode == 1) ? 2 : 1;
`ifdef LIFE_AUTO_STOP_EN
      else if (dok && board_same && old_mode == 1) m_mode = 2;
`endif
      if (old_mode != 1 || tick || spd_in != m_spd) m_presc = 0;
      else m_presc = m_presc + 1;
      if (tick && m_busy) m_over = 1;
      if (start) m_busy = 1;
      else if (dok) m_busy = 0;
      if (dok) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    m_spd = spd_in;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        lvl[i] = 0; pls[i] = 0;
        for (int j = 0; j <= DEB; j++) hist[i][j] = 0;
      end else begin
        all_diff = 1;
        for (int j = 1; j <= DEB; j++) if (hist[i][j] == lvl[i]) all_diff = 0;
        nl = all_diff ? !lvl[i] : lvl[i];
        pls[i] = nl && !lvl[i];
        lvl[i] = nl;
        for (int j = DEB; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = raw[i];
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned k_lat_min = 2, k_lat_max = 2;
  int unsigned k_press_pm [3] = '{0, 0, 0};  // spontaneous press chance per 1000 cycles
  int unsigned k_spurious_pct = 0, k_same_pct = 0, k_speed_pct = 0;
  bit          k_hold_done = 0, k_done_on_clear = 0;
  logic [2:0]  k_speed = '0;
  bit          req [3] = '{0, 0, 0};
  int unsigned hold_left [3] = '{0, 0, 0};
  int unsigned cool_left [3] = '{0, 0, 0};
  int unsigned press_age [3] = '{0, 0, 0};
  int          done_timer = -1;

  task automatic check_outputs();
    check_eq("mode",    32'(mode_o),    32'(1 << m_mode));
    check_eq("setup",   32'(setup_en),  32'(m_mode == 0));
    check_eq("start",   32'(gen_start), 32'(model_start()));
    check_eq("busy",    32'(busy),      32'(m_busy));
    check_eq("cnt",     32'(gen_cnt),   32'(m_cnt));
    check_eq("overrun", 32'(overrun),   32'(m_over));
  endtask

  task automatic drive_and_step();
    bit b [3];
    bit d;
    for (int i = 0; i < 3; i++) begin
      if (hold_left[i] > 0) begin
        hold_left[i]--;
        press_age[i]++;
        // Contact bounce in the first couple of cycles of a press.
        b[i] = !((press_age[i] <= 2) && ($urandom_range(0, 2) == 0));
        if (hold_left[i] == 0) cool_left[i] = DEB + 4 + $urandom_range(0, 4);
      end else begin
        b[i] = 0;
        if (cool_left[i] > 0) cool_left[i]--;
        else if (req[i] || ($urandom_range(0, 999) < k_press_pm[i])) begin
          req[i] = 0;
          hold_left[i] = DEB + 3 + $urandom_range(0, 4);
          press_age[i] = 0;
        end
      end
    end
    d = 0;
    if (model_start()) done_timer = int'($urandom_range(k_lat_min, k_lat_max));
    else if (done_timer > 0 && !k_hold_done) begin
      done_timer--;
      if (done_timer == 0) begin d = 1; done_timer = -1; end
    end
    if ($urandom_range(0, 99) < k_spurious_pct) d = 1;
    if (k_done_on_clear && pls[0]) d = 1;
    if ($urandom_range(0, 99) < k_speed_pct) k_speed = 3'($urandom_range(0, 7));
    btn_clear  = b[0];
    btn_run    = b[1];
    btn_step   = b[2];
    gen_done   = d;
    board_same = ($urandom_range(0, 99) < k_same_pct);
    speed      = k_speed;
    model_step(b[0], b[1], b[2], d, k_speed);
  endtask

  task automatic run_phase(input int unsigned ncyc);
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_outputs();
      drive_and_step();
    end
  endtask

  task automatic apply_reset(input int unsigned ncyc);
    @(negedge clk);
    reset = 1; btn_clear = 0; btn_run = 0; btn_step = 0; gen_done = 0; board_same = 0;
    for (int i = 0; i < 3; i++) begin hold_left[i] = 0; cool_left[i] = 0; req[i] = 0; end
    done_timer = -1;
    repeat (ncyc) @(negedge clk);
    model_reset();
    check_outputs();
    reset = 0;
    drive_and_step();
  endtask

  initial begin
    reset = 1; btn_clear = 0; btn_run = 0; btn_step = 0;
    speed = '0; gen_done = 0; board_same = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 0;
    drive_and_step();

    // Idle in SET with stray done pulses: no start may appear.
    k_spurious_pct = 10;
    run_phase(30);
    k_spurious_pct = 0;

    // RUN at speed 0, done 2 cycles after each start.
    req[1] = 1;
    run_phase(80);
    k_speed = 3'd1;
    run_phase(50);

    // Withhold done: single start, then overrun.
    k_hold_done = 1;
    run_phase(30);

    // Pause while busy, then release done; step while busy and while idle.
    req[1] = 1;
    run_phase(30);
    req[2] = 1;
    run_phase(30);
    k_hold_done = 0;
    run_phase(10);
    req[2] = 1;
    run_phase(30);
    k_hold_done = 1;
    req[2] = 1;
    run_phase(30);
    req[2] = 1;
    run_phase(30);
    k_hold_done = 0;
    run_phase(10);

    // Clear landing on the same cycle as a done while busy.
    if (m_mode != 1) req[1] = 1;
    run_phase(40);
    k_hold_done = 1;
    run_phase(12);
    k_done_on_clear = 1;
    req[0] = 1;
    run_phase(40);
    k_done_on_clear = 0;
    k_hold_done = 0;

    // Fastest speed with short latency: counter wraps several times.
    k_speed = 3'd7; k_lat_min = 1; k_lat_max = 1;
    req[1] = 1;
    run_phase(150);

`ifdef LIFE_AUTO_STOP_EN
    k_same_pct = 100; k_speed = 3'd2; k_lat_min = 2; k_lat_max = 2;
    run_phase(40);
    k_same_pct = 0;
`endif

    apply_reset(2);

    // Free-running mix of everything.
    k_press_pm = '{15, 40, 40};
    k_spurious_pct = 5; k_same_pct = 20; k_speed_pct = 3;
    k_lat_min = 1; k_lat_max = 12;
    run_phase(1500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
